tx_fifo: RTL
============

Name: tx_fifo

Overview:
Frame-aware byte FIFO feeding the MAC transmit state machine. Stores complete Ethernet frames (destination address through payload, no preamble/FCS) written by the host-side logic. Presents them show-ahead on the fifo_* interface. Supports retry rewind to the start of the current frame after a collision, and drops frames that overflow the buffer.

Parameters:
ADDR_WIDTH, 11, log2 of buffer depth in bytes (DEPTH = 2**ADDR_WIDTH = 2048, at least one 1518-byte frame).

Ports:
clock  input  1  single clock domain.
reset  input  1  asynchronous, active-high; clears all state.
data_in  input  8  write byte.
data_in_write  input  1  write strobe, one byte per cycle.
data_in_start  input  1  qualifies data_in as first byte of a frame.
data_in_end  input  1  qualifies data_in as last byte of a frame.
data_in_full  output  1  buffer holds DEPTH bytes.
frame_dropped  output  1  one-cycle pulse when a partial frame is discarded.
fifo_data  output  8  head byte (show-ahead); 0 when no complete frame is stored.
fifo_data_read  input  1  consume head byte.
fifo_data_start  output  1  head byte carries the start flag.
fifo_data_end  output  1  head byte carries the end flag.
fifo_data_available  output  1  at least one complete frame is stored.
fifo_retry  input  1  rewind the read pointer to the start of the current frame; may be held high for several cycles.

Behaviour:
- Storage: DEPTH x 10 bits {end, start, data}, written synchronously and read asynchronously at rd_ptr.
- Pointers are ADDR_WIDTH+1 bits and wrap naturally. Registers:
  - wr_ptr: next write location.
  - wr_frame_ptr: start of the frame being written.
  - rd_ptr: next read location.
  - rd_frame_ptr: start of the frame being read.
  - frame_count: ADDR_WIDTH+1 bits.
- Occupancy = wr_ptr - rd_frame_ptr. Space is freed only when a frame's end byte is read, never per byte. data_in_full = (occupancy == DEPTH).
- fifo_data_available = (frame_count != 0). fifo_data, fifo_data_start and fifo_data_end reflect mem[rd_ptr] when available, else 0.
- Reset values: all pointers 0, frame_count 0, write state WR_IDLE. All outputs 0.
- Read side:
  - Read accepted when fifo_data_read=1, fifo_retry=0 and frame_count!=0; rd_ptr increments.
  - Accepted read of an end-flagged byte sets rd_frame_ptr <= rd_ptr+1 and decrements frame_count. The head updates the next cycle.
  - fifo_retry=1 forces rd_ptr <= rd_frame_ptr and ignores fifo_data_read that cycle (retry wins).
  - Reads with frame_count==0 are ignored.
- Write state machine:
  - WR_IDLE:
    - Write with start: store the byte, set wr_frame_ptr <= wr_ptr. If end is also set, commit and stay in WR_IDLE; otherwise go to WR_FRAME.
    - Write without start: ignored.
  - WR_FRAME:
    - Write with end: store the byte, commit, go to WR_IDLE.
    - Write with start: discard the partial frame (wr_ptr <= wr_frame_ptr), pulse frame_dropped, store this byte as a new frame start.
    - Write while full: wr_ptr <= wr_frame_ptr, pulse frame_dropped, go to WR_DROP.
  - WR_DROP:
    - Writes are ignored until a byte with end arrives, then go to WR_IDLE.
    - A write with start (and not full) is handled as in WR_IDLE.
  - In any state, a write with start while full is ignored and pulses frame_dropped.
  - Commit = increment frame_count and set wr_frame_ptr <= wr_ptr+1.
- Simultaneous events:
  - Write-commit and read-commit in the same cycle leave frame_count unchanged.
  - Writes and reads proceed concurrently on different frames. The reader never passes the last committed end byte.
  - data_in_full is evaluated on pre-cycle occupancy; a read commit in the same cycle does not admit the write.
- Reset mid-frame discards everything, including committed frames. Outputs go to 0 asynchronously.

Test Plan:
- Write one 60-byte frame (start on byte 0x00, end on byte 0x3B) -> fifo_data_available rises the cycle after the end write; 60 show-ahead reads return 0x00..0x3B; available falls after the end read; occupancy returns to 0.
- Read 20 bytes of a 100-byte frame, hold fifo_retry for 3 cycles with fifo_data_read=1 -> head returns to byte 0 with start=1; full re-read is identical; frame_count is still 1 until the end byte is read.
- Write two back-to-back 64-byte frames -> frame_count=2; reading frame 1's end byte drops the count to 1; frame 2's start byte is the head the next cycle.
- ADDR_WIDTH=6, write a 70-byte frame with no committed frames -> data_in_full asserts at 64 bytes; the next write pulses frame_dropped; wr_ptr rewinds; later bytes are ignored until end; available stays 0; the following 10-byte frame is stored correctly.
- Write a frame's end byte in the same cycle the reader consumes the previous frame's end byte -> frame_count stays 1 and the new frame's start byte becomes the head.
- Assert reset halfway through writing a frame with one committed frame pending -> all outputs 0 and available=0 immediately; a new 64-byte frame after reset is read back intact.

Source files
------------

// File: rtl/tx_fifo_if.sv
// ---------------------------------------------------------------------------
// tx_fifo_if : byte/frame bus between host-side writer, tx_fifo and the MAC
// transmit reader.
//
// Handshake semantics (both directions, single clock domain):
//   - Write side: one byte is offered per cycle in which data_in_write=1.
//     There is no ready signal. The writer watches data_in_full and
//     frame_dropped, and the FIFO decides frame-wise whether to keep data.
//   - Read side: fifo_data* is show-ahead (valid = fifo_data_available).
//     A byte is consumed on a clock edge where fifo_data_read=1,
//     fifo_retry=0 and fifo_data_available=1. fifo_retry has priority over
//     fifo_data_read.
//
// Modports:
//   slave  : the FIFO (receives data_in*, fifo_data_read, fifo_retry)
//   master : the environment driving the FIFO
// ---------------------------------------------------------------------------
interface tx_fifo_if;
  logic [7:0] data_in;
  logic       data_in_write;
  logic       data_in_start;
  logic       data_in_end;
  logic       data_in_full;
  logic       frame_dropped;
  logic [7:0] fifo_data;
  logic       fifo_data_read;
  logic       fifo_data_start;
  logic       fifo_data_end;
  logic       fifo_data_available;
  logic       fifo_retry;

  modport slave (
    input  data_in, data_in_write, data_in_start, data_in_end,
    input  fifo_data_read, fifo_retry,
    output data_in_full, frame_dropped,
    output fifo_data, fifo_data_start, fifo_data_end, fifo_data_available
  );

  modport master (
    output data_in, data_in_write, data_in_start, data_in_end,
    output fifo_data_read, fifo_retry,
    input  data_in_full, frame_dropped,
    input  fifo_data, fifo_data_start, fifo_data_end, fifo_data_available
  );
endinterface

// File: rtl/tx_fifo.sv
// ---------------------------------------------------------------------------
// tx_fifo : frame-aware byte FIFO feeding the MAC transmit state machine.
//
// Stores complete frames (DA..payload) written by the host. The frames are
// presented show-ahead. The reader can rewind to the start of its current
// frame (collision retry). A frame that overflows the buffer is discarded.
//
// Ports:
//   clock           : single clock domain
//   reset           : asynchronous, active-high; clears all state
//   bus             : tx_fifo_if.slave (write side, read side, status)
//   o_dbg_wr_state  : write FSM state (WR_IDLE=0, WR_FRAME=1, WR_DROP=2)
// ---------------------------------------------------------------------------
module tx_fifo #(
  parameter int ADDR_WIDTH = 11
) (
  input  logic           clock,
  input  logic           reset,
  tx_fifo_if.slave       bus,
  output logic [1:0]     o_dbg_wr_state
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_P = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0] ONE_P   = {{ADDR_WIDTH{1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    WR_IDLE  = 2'd0,
    WR_FRAME = 2'd1,
    WR_DROP  = 2'd2
  } wr_state_t;

  // Storage word: {end, start, data}
  logic [9:0] r_mem [DEPTH];

  wr_state_t           r_state;
  logic [ADDR_WIDTH:0] r_wr_ptr;
  logic [ADDR_WIDTH:0] r_wr_frame_ptr;
  logic [ADDR_WIDTH:0] r_rd_ptr;
  logic [ADDR_WIDTH:0] r_rd_frame_ptr;
  logic [ADDR_WIDTH:0] r_frame_count;
  logic                r_frame_dropped;

  logic                w_full;
  logic                w_avail;
  logic [9:0]          w_head;
  logic                w_wr;
  logic                w_start_ok;
  logic                w_mem_we;
  logic [ADDR_WIDTH:0] w_mem_addr;
  logic                w_wr_commit;
  logic                w_rd_accept;
  logic                w_rd_commit;

  // Space is only returned when the reader retires a whole frame, so the
  // occupancy is measured from the start of the frame being read.
  assign w_full  = ((r_wr_ptr - r_rd_frame_ptr) == DEPTH_P);
  assign w_avail = (r_frame_count != '0);
  assign w_head  = r_mem[r_rd_ptr[ADDR_WIDTH-1:0]];
  assign w_wr    = bus.data_in_write;

  assign w_start_ok = w_wr && bus.data_in_start && !w_full;

  // Memory write decode. It mirrors the FSM below: in WR_FRAME a new start
  // byte overwrites the discarded partial frame from its first location.
  always_comb begin
    w_mem_we   = 1'b0;
    w_mem_addr = r_wr_ptr;
    case (r_state)
      WR_FRAME: begin
        if (w_wr && !w_full) begin
          w_mem_we   = 1'b1;
          w_mem_addr = bus.data_in_start ? r_wr_frame_ptr : r_wr_ptr;
        end
      end
      default: begin
        if (w_start_ok) begin
          w_mem_we   = 1'b1;
          w_mem_addr = r_wr_ptr;
        end
      end
    endcase
  end

  assign w_wr_commit = w_mem_we && bus.data_in_end;

  // Retry wins over read; reads with nothing committed are ignored.
  assign w_rd_accept = bus.fifo_data_read && !bus.fifo_retry && w_avail;
  assign w_rd_commit = w_rd_accept && w_head[9];

  always_ff @(posedge clock) begin
    if (w_mem_we) begin
      r_mem[w_mem_addr[ADDR_WIDTH-1:0]] <= {bus.data_in_end, bus.data_in_start, bus.data_in};
    end
  end

  // Write FSM, read pointers and frame counter.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state         <= WR_IDLE;
      r_wr_ptr        <= '0;
      r_wr_frame_ptr  <= '0;
      r_rd_ptr        <= '0;
      r_rd_frame_ptr  <= '0;
      r_frame_count   <= '0;
      r_frame_dropped <= 1'b0;
    end else begin
      r_frame_dropped <= 1'b0;

      case (r_state)
        WR_FRAME: begin
          if (w_wr) begin
            if (w_full) begin
              r_wr_ptr        <= r_wr_frame_ptr;
              r_frame_dropped <= 1'b1;
              r_state         <= WR_DROP;
            end else if (bus.data_in_start) begin
              // Restart: the new start byte reuses the partial frame's slot.
              r_frame_dropped <= 1'b1;
              r_wr_ptr        <= r_wr_frame_ptr + ONE_P;
              if (bus.data_in_end) begin
                r_wr_frame_ptr <= r_wr_frame_ptr + ONE_P;
                r_state        <= WR_IDLE;
              end
            end else begin
              r_wr_ptr <= r_wr_ptr + ONE_P;
              if (bus.data_in_end) begin
                r_wr_frame_ptr <= r_wr_ptr + ONE_P;
                r_state        <= WR_IDLE;
              end
            end
          end
        end

        default: begin  // WR_IDLE and WR_DROP
          if (w_wr && bus.data_in_start) begin
            if (w_full) begin
              r_frame_dropped <= 1'b1;
            end else begin
              r_wr_ptr <= r_wr_ptr + ONE_P;
              if (bus.data_in_end) begin
                r_wr_frame_ptr <= r_wr_ptr + ONE_P;
                r_state        <= WR_IDLE;
              end else begin
                r_wr_frame_ptr <= r_wr_ptr;
                r_state        <= WR_FRAME;
              end
            end
          end else if (r_state == WR_DROP && w_wr && bus.data_in_end) begin
            r_state <= WR_IDLE;
          end
        end
      endcase

      if (bus.fifo_retry) begin
        r_rd_ptr <= r_rd_frame_ptr;
      end else if (w_rd_accept) begin
        r_rd_ptr <= r_rd_ptr + ONE_P;
      end

      if (w_rd_commit) begin
        r_rd_frame_ptr <= r_rd_ptr + ONE_P;
      end

      r_frame_count <= r_frame_count
                       + {{ADDR_WIDTH{1'b0}}, w_wr_commit}
                       - {{ADDR_WIDTH{1'b0}}, w_rd_commit};
    end
  end

  assign bus.data_in_full        = w_full;
  assign bus.frame_dropped       = r_frame_dropped;
  assign bus.fifo_data_available = w_avail;
  assign bus.fifo_data           = w_avail ? w_head[7:0] : 8'h00;
  assign bus.fifo_data_start     = w_avail & w_head[8];
  assign bus.fifo_data_end       = w_avail & w_head[9];

  assign o_dbg_wr_state = r_state;

endmodule
